// File: rtl/uc_lsu_pkg.sv
// uc_lsu_pkg: shared FSM state type, funct3 size/sign codes, access-kind encodings
// and the funct3 legality helper for the load/store unit.
package uc_lsu_pkg;

    typedef enum logic [1:0] {IDLE, LM_RD, EXT_WAIT} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ACCESS_READ  = 2'd0;
    localparam logic [1:0] ACCESS_WRITE = 2'd1;
    localparam logic [1:0] ACCESS_CODE  = 2'd2;

    // Stores only reject the unsigned-variant codes; loads accept the five RV32I sizes.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? !f3[2]
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/uc_lsu_align.sv
// uc_lsu_align: combinational byte-lane logic.
// Ports: funct3/off select size and byte offset; wdata -> be + lane-replicated wrep;
// rdata -> rext, shifted down by the offset and sign/zero extended.
module uc_lsu_align
    import uc_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] rext
);

    logic [31:0] sh;
    logic        sx;

    // Halfwords use the truncated alignment {off[1],0}, so misaligned halves stay in-word.
    assign be   = funct3[1] ? 4'b1111 : funct3[0] ? (4'b0011 << {off[1], 1'b0}) : (4'b0001 << off);
    assign wrep = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    assign sh   = rdata >> {off, 3'b000};
    assign sx   = !funct3[2];
    assign rext = funct3[1] ? sh
                : funct3[0] ? {{16{sh[15] & sx}}, sh[15:0]}
                :             {{24{sh[7] & sx}}, sh[7:0]};

endmodule

// File: rtl/uc_lsu.sv
// uc_lsu: RV32I load/store unit routing valid/ready requests to local BRAM or an external bus.
// Ports: CLK/RST (sync, active-high); req_* request in, rsp_* one-cycle response out;
// lm_* BRAM data port (1-cycle read latency); ext_* external bus held until ext_ack.
// Build option: define UC_LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses
// into error responses instead of truncated-alignment accesses.
module uc_lsu
    import uc_lsu_pkg::*;
#(
    parameter int         LM_BITS     = 15,
    parameter logic [3:0] LM_TADDR    = 4'h1,
    parameter int         EXT_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [LM_BITS-3:0]   lm_addr,
    output logic [3:0]           lm_we,
    output logic [31:0]          lm_wdata,
    input  logic [31:0]          lm_rdata,
    output logic                 ext_valid,
    output logic                 ext_we,
    output logic [31:0]          ext_addr,
    output logic [3:0]           ext_be,
    output logic [31:0]          ext_wdata,
    input  logic                 ext_ack,
    input  logic [31:0]          ext_rdata
);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic        acc, is_lm, misal, bad;
    logic [3:0]  st_be, ld_be;
    logic [31:0] st_wrep, st_rext, ld_wrep, ld_rext;
    logic [67:0] unused;

`ifdef UC_LSU_MISALIGN_TRAP_EN
    assign misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1] && req_addr[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign req_ready = state == IDLE;
    assign acc       = req_valid && req_ready;
    assign is_lm     = req_addr[31:28] == LM_TADDR;
    assign bad       = !f3_legal(req_we, req_funct3) || misal;
    assign lm_addr   = req_addr[LM_BITS-1:2];
    assign lm_wdata  = st_wrep;
    assign lm_we     = (acc && !RST && is_lm && req_we && !bad) ? st_be : 4'b0000;
    assign unused    = {ld_be, ld_wrep, st_rext};

    uc_lsu_align u_st (
        .funct3(req_funct3), .off(req_addr[1:0]), .wdata(req_wdata), .rdata(32'h0),
        .be(st_be), .wrep(st_wrep), .rext(st_rext)
    );

    // Load extraction works on the registered size/offset against whichever source answered.
    uc_lsu_align u_ld (
        .funct3(f3), .off(off), .wdata(32'h0), .rdata(state == LM_RD ? lm_rdata : ext_rdata),
        .be(ld_be), .wrep(ld_wrep), .rext(ld_rext)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            ext_valid <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= 32'h0;
            ext_be    <= 4'h0;
            ext_wdata <= 32'h0;
            cnt       <= 16'h0;
            off       <= 2'b00;
            f3        <= 3'b000;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    off <= req_addr[1:0];
                    f3  <= req_funct3;
                    if (bad || (is_lm && req_we)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= bad;
                        rsp_rdata <= 32'h0;
                    end else if (is_lm) begin
                        state <= LM_RD;
                    end else begin
                        state     <= EXT_WAIT;
                        ext_valid <= 1'b1;
                        ext_we    <= req_we;
                        ext_addr  <= req_addr;
                        ext_be    <= st_be;
                        ext_wdata <= st_wrep;
                        cnt       <= 16'h0;
                    end
                end
                LM_RD: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ld_rext;
                end
                EXT_WAIT: begin
                    // Ack wins over an expiring timeout in the same cycle.
                    if (ext_ack || cnt == 16'(EXT_TIMEOUT - 1)) begin
                        state     <= IDLE;
                        ext_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !ext_ack;
                        rsp_rdata <= (ext_ack && !ext_we) ? ld_rext : 32'h0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_lsu.sv
// tb_uc_lsu: randomized self-checking bench for uc_lsu against a byte-level memory/bus model.
module tb_uc_lsu;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [12:0] lm_addr;
    logic [3:0]  lm_we;
    logic [31:0] lm_wdata, lm_rdata;
    logic        ext_valid, ext_we, ext_ack;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic [3:0]  ext_be;

    always #5 CLK = ~CLK;

    uc_lsu #(.LM_BITS(15), .LM_TADDR(4'h1), .EXT_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lm_addr(lm_addr), .lm_we(lm_we), .lm_wdata(lm_wdata), .lm_rdata(lm_rdata),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_be(ext_be),
        .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
    );

    logic [31:0] bram [0:8191];
    logic [7:0]  ref_mem [0:32767];

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (lm_we[i]) bram[lm_addr][i*8 +: 8] <= lm_wdata[i*8 +: 8];
        lm_rdata <= bram[lm_addr];
    end

    int total = 0;
    int bad = 0;
    logic [31:0] seen_rdata, seen_wdata;
    logic [3:0]  seen_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] o);
        int n;
        logic [31:0] v, r;
        n = nbytes(f3);
        v = w >> (8 * o);
        r = 32'h0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = v[i*8 +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) r[i*8 +: 8] = 8'hFF;
        return r;
    endfunction

    // d = cycles the bus stays silent before acking (d >= TMO means never ack); xr = bus read word.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] xr);
        logic lm, illegal, misal, err, ext;
        logic [3:0] ebe;
        logic [31:0] ewd, erd, w;
        int n, base, lat, widx, k;
        lm = a[31:28] == 4'h1;
        n = nbytes(f3);
        base = int'(a[1:0]) / n * n;
        illegal = we ? f3[2] : (f3 == 3'd3 || f3 >= 3'd6);
        misal = 1'b0;
`ifdef UC_LSU_MISALIGN_TRAP_EN
        misal = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
        widx = int'(a[14:2]);
        ebe = 4'h0;
        ewd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= base && i < base + n) ebe[i] = 1'b1;
            ewd[i*8 +: 8] = wd[(i % n)*8 +: 8];
        end
        w = {ref_mem[widx*4+3], ref_mem[widx*4+2], ref_mem[widx*4+1], ref_mem[widx*4]};
        ext = 1'b0;
        if (illegal || misal) begin lat = 1; err = 1'b1; erd = 32'h0; end
        else if (lm && we) begin lat = 1; err = 1'b0; erd = 32'h0; end
        else if (lm) begin lat = 2; err = 1'b0; erd = extract(w, f3, a[1:0]); end
        else if (d < TMO) begin ext = 1'b1; lat = d + 2; err = 1'b0; erd = we ? 32'h0 : extract(xr, f3, a[1:0]); end
        else begin ext = 1'b1; lat = TMO + 1; err = 1'b1; erd = 32'h0; end
        @(posedge CLK); #1;
        check("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        #1;
        check("req_ready", {31'h0, req_ready}, 32'h1);
        check("lm_we", {28'h0, lm_we}, {28'h0, (lm && we && !err) ? ebe : 4'h0});
        if (lm && we && !err) begin
            check("lm_addr", {19'h0, lm_addr}, {19'h0, a[14:2]});
            check("lm_wdata", lm_wdata, ewd);
        end
        seen_we = lm_we;
        seen_wdata = lm_wdata;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k <= 20) begin
            check("ext_valid", {31'h0, ext_valid}, {31'h0, ext});
            if (ext) begin
                check("ext_addr", ext_addr, a);
                check("ext_we", {31'h0, ext_we}, {31'h0, we});
                if (we) begin
                    check("ext_be", {28'h0, ext_be}, {28'h0, ebe});
                    check("ext_wdata", ext_wdata, ewd);
                end
            end
            ext_ack = ext && k == d + 1;
            ext_rdata = ext_ack ? xr : $urandom;
            @(posedge CLK); #1;
            ext_ack = 1'b0;
            k++;
        end
        check("latency", k, lat);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, err});
        check("rsp_rdata", rsp_rdata, erd);
        check("ext_idle", {31'h0, ext_valid}, 32'h0);
        seen_rdata = rsp_rdata;
        if (lm && we && !err)
            for (int i = 0; i < 4; i++)
                if (ebe[i]) ref_mem[widx*4+i] = ewd[i*8 +: 8];
    endtask

    initial begin
        logic we;
        logic [2:0] f3;
        logic [31:0] a;
        for (int i = 0; i < 8192; i++) bram[i] = 32'h0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h0;
        RST = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1000_0000; req_wdata = 32'h1;
        ext_ack = 1'b0; ext_rdata = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_lm_we", {28'h0, lm_we}, 32'h0);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp", {31'h0, rsp_valid}, 32'h0);
        check("rst_ext", {31'h0, ext_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        req_valid = 1'b0;
        RST = 1'b0;

        access(1'b1, 3'b010, 32'h1000_0010, 32'hDEAD_BEEF, 0, 32'h0);
        access(1'b0, 3'b100, 32'h1000_0013, 32'h0, 0, 32'h0);
        check("tp_lbu", seen_rdata, 32'h0000_00DE);
        access(1'b0, 3'b000, 32'h1000_0012, 32'h0, 0, 32'h0);
        check("tp_lb", seen_rdata, 32'hFFFF_FFAD);
        access(1'b1, 3'b001, 32'h1000_0012, 32'h0000_1234, 0, 32'h0);
        check("tp_sh_we", {28'h0, seen_we}, 32'hC);
        check("tp_sh_wdata", seen_wdata, 32'h1234_1234);
        access(1'b0, 3'b010, 32'h2000_0000, 32'h0, 3, 32'hCAFE_F00D);
        check("tp_ext", seen_rdata, 32'hCAFE_F00D);
        access(1'b0, 3'b010, 32'h2000_0004, 32'h0, TMO, 32'h0);
        access(1'b1, 3'b000, 32'h3000_0001, 32'h0000_00A5, TMO - 1, 32'h0);
        access(1'b0, 3'b010, 32'h1000_0002, 32'h0, 0, 32'h0);
        access(1'b0, 3'b011, 32'h1000_0010, 32'h0, 0, 32'h0);
        access(1'b1, 3'b100, 32'h2000_0010, 32'h5, 0, 32'h0);

        @(posedge CLK); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3000_0004;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check("mid_ext", {31'h0, ext_valid}, 32'h1);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_ext", {31'h0, ext_valid}, 32'h0);
        check("mid_rst_rsp", {31'h0, rsp_valid}, 32'h0);
        RST = 1'b0;
        check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("mid_rst_quiet", {31'h0, rsp_valid}, 32'h0);
        end

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (we && f3 == 3'd3) f3 = 3'd2;
            a = ($urandom_range(0, 9) < 7) ? {4'h1, 22'h0, 6'($urandom)}
                                           : {4'($urandom_range(2, 15)), 28'($urandom)};
            access(we, f3, a, $urandom, $urandom_range(0, TMO + 1), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
